// File: rtl/badder_accum.sv
// WIDTH-bit carry-chain adder cell with selectable add/sub/accumulate/count and registered result.
// Optional saturation of accumulate/count on carry-out: define BADDER_ACCUM_SAT_EN.
module badder_accum #(
  parameter int unsigned     WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             QCK,
  input  logic             QRTN,
  input  logic             QEN,
  input  logic             QST,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic [WIDTH-1:0] FZ,
  output logic             CO,
  output logic [WIDTH-1:0] AQZ,
  output logic             CQZ,
  output logic             OVZ,
  output logic             TCZ
);

  logic [WIDTH-1:0] r_aqz;
  logic             r_cqz;
  logic             r_ovz;

  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ov;
  logic             w_sat;
  logic [WIDTH-1:0] w_aqz_d;
  logic             w_cqz_d;
  logic             w_ovz_d;

  always_comb begin
    w_opa = A;
    w_opb = B;
    w_cin = CI;
    unique case (MODE)
      2'b00: begin
        w_opa = A;
        w_opb = B;
        w_cin = CI;
      end
      2'b01: begin
        w_opa = A;
        w_opb = ~B;
        w_cin = ~CI;
      end
      2'b10: begin
        w_opa = r_aqz;
        w_opb = A;
        w_cin = CI;
      end
      2'b11: begin
        w_opa = r_aqz;
        w_opb = '0;
        w_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
  assign FZ    = w_sum[WIDTH-1:0];
  // Subtract reports borrow, the inverse of the raw carry.
  assign CO    = (MODE == 2'b01) ? ~w_sum[WIDTH] : w_sum[WIDTH];
  assign w_ov  = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) & (w_sum[WIDTH-1] != w_opa[WIDTH-1]);

`ifdef BADDER_ACCUM_SAT_EN
  assign w_sat = MODE[1] & w_sum[WIDTH];
`else
  assign w_sat = 1'b0;
`endif

  always_comb begin
    w_aqz_d = r_aqz;
    w_cqz_d = r_cqz;
    w_ovz_d = r_ovz;
    if (QST) begin
      w_aqz_d = A;
      w_cqz_d = 1'b0;
      w_ovz_d = 1'b0;
    end else if (QEN) begin
      w_aqz_d = w_sat ? {WIDTH{1'b1}} : FZ;
      w_cqz_d = CO;
      // Overflow is sticky while accumulating or counting.
      w_ovz_d = MODE[1] ? (r_ovz | w_ov) : w_ov;
    end
  end

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      r_aqz <= RESET_VAL;
      r_cqz <= 1'b0;
      r_ovz <= 1'b0;
    end else begin
      r_aqz <= w_aqz_d;
      r_cqz <= w_cqz_d;
      r_ovz <= w_ovz_d;
    end
  end

  assign AQZ = r_aqz;
  assign CQZ = r_cqz;
  assign OVZ = r_ovz;
  assign TCZ = (MODE == 2'b11) & (&r_aqz);

endmodule

// File: tb/tb_badder_accum.sv
// Self-checking bench for badder_accum: vector table with a scoreboard for registered results,
// plus hand-written reset and load sequences.
module tb_badder_accum;

`ifdef BADDER_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       QCK, QRTN, QEN, QST, CI;
  logic [1:0] MODE;
  logic [3:0] A, B, FZ, AQZ;
  logic       CO, CQZ, OVZ, TCZ;

  badder_accum #(.WIDTH(4), .RESET_VAL(4'h5)) dut (
    .QCK(QCK), .QRTN(QRTN), .QEN(QEN), .QST(QST), .MODE(MODE), .A(A), .B(B), .CI(CI),
    .FZ(FZ), .CO(CO), .AQZ(AQZ), .CQZ(CQZ), .OVZ(OVZ), .TCZ(TCZ)
  );

  initial QCK = 1'b0;
  always #5 QCK = ~QCK;

  typedef struct packed {
    logic       qst;
    logic       qen;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] fz;
    logic       co;
    logic [3:0] aqz;
    logic       cqz;
    logic       ovz;
    logic       tcz;
  } vec_t;

  typedef struct packed {
    logic [3:0] aqz;
    logic       cqz;
    logic       ovz;
    logic       tcz;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  exp_t sbq [$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  initial begin
    //          qst   qen   mode   a      b      ci    fz     co    aqz    cqz   ovz   tcz
    vecs[0]  = '{1'b0, 1'b1, 2'd0, 4'd7,  4'd9, 1'b1, 4'd1,  1'b1, 4'd1,  1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 4'd3,  4'd5, 1'b0, 4'd14, 1'b1, 4'd14, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 4'd2,  4'd5, 1'b0, 4'd13, 1'b1, 4'd13, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 4'd8,  4'd1, 1'b0, 4'd7,  1'b0, 4'd7,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 4'd13, 4'd0, 1'b0, 4'd13, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd3, 4'd0,  4'd0, 1'b0, 4'd14, 1'b0, 4'd14, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 4'd0,  4'd0, 1'b0, 4'd15, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 4'd0,  4'd0, 1'b0, 4'd0,  1'b1,
                 SAT ? 4'd15 : 4'd0, 1'b1, 1'b0, SAT};
    // QEN low: registers hold while FZ/CO follow the inputs.
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 4'd5,  4'd6, 1'b0, 4'd11, 1'b0,
                 SAT ? 4'd15 : 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 4'd4,  4'd4, 1'b0, 4'd0,  1'b0,
                 SAT ? 4'd15 : 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'd3, 4'd0,  4'd0, 1'b0, SAT ? 4'd0 : 4'd1, SAT,
                 SAT ? 4'd15 : 4'd0, 1'b1, 1'b0, SAT};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 4'd6,  4'd0, 1'b0, SAT ? 4'd5 : 4'd6, SAT,
                 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 4'd3,  4'd0, 1'b0, 4'd9,  1'b0, 4'd9,  1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd2, 4'd0,  4'd0, 1'b0, 4'd9,  1'b0, 4'd9,  1'b0, 1'b1, 1'b0};
    // QST wins over QEN and clears the sticky overflow.
    vecs[14] = '{1'b1, 1'b1, 2'd2, 4'd0,  4'd0, 1'b0, 4'd9,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0};

    QRTN = 1'b0; QEN = 1'b0; QST = 1'b0; MODE = 2'd0; A = '0; B = '0; CI = 1'b0;
    #12;
    chk("reset aqz", 32'(AQZ), 32'd5);
    chk("reset cqz", 32'(CQZ), 32'd0);
    chk("reset ovz", 32'(OVZ), 32'd0);
    @(negedge QCK);
    QRTN = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge QCK);
      QST = vecs[i].qst; QEN = vecs[i].qen; MODE = vecs[i].mode;
      A = vecs[i].a; B = vecs[i].b; CI = vecs[i].ci;
      #1;
      chk($sformatf("vec%0d fz", i), 32'(FZ), 32'(vecs[i].fz));
      chk($sformatf("vec%0d co", i), 32'(CO), 32'(vecs[i].co));
      sbq.push_back('{vecs[i].aqz, vecs[i].cqz, vecs[i].ovz, vecs[i].tcz});
      @(posedge QCK);
      #1;
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL vec%0d scoreboard: got empty queue expected one entry", i);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("vec%0d aqz", i), 32'(AQZ), 32'(e.aqz));
        chk($sformatf("vec%0d cqz", i), 32'(CQZ), 32'(e.cqz));
        chk($sformatf("vec%0d ovz", i), 32'(OVZ), 32'(e.ovz));
        chk($sformatf("vec%0d tcz", i), 32'(TCZ), 32'(e.tcz));
      end
    end

    // Reset asserted between edges in the middle of a count.
    @(negedge QCK);
    QST = 1'b1; QEN = 1'b0; MODE = 2'd0; A = 4'd13;
    @(posedge QCK); #1;
    chk("mid load aqz", 32'(AQZ), 32'd13);
    @(negedge QCK);
    QST = 1'b0; QEN = 1'b1; MODE = 2'd3;
    @(posedge QCK); #1;
    chk("mid count aqz", 32'(AQZ), 32'd14);
    #2;
    QRTN = 1'b0; QST = 1'b1; QEN = 1'b1; A = 4'd9;
    #1;
    chk("async rst aqz", 32'(AQZ), 32'd5);
    chk("async rst cqz", 32'(CQZ), 32'd0);
    chk("async rst ovz", 32'(OVZ), 32'd0);
    chk("async rst tcz", 32'(TCZ), 32'd0);
    @(posedge QCK); #1;
    chk("held rst aqz", 32'(AQZ), 32'd5);
    @(negedge QCK);
    QRTN = 1'b1; QST = 1'b0; QEN = 1'b1; MODE = 2'd3;
    @(posedge QCK); #1;
    chk("post rst aqz", 32'(AQZ), 32'd6);
    chk("post rst cqz", 32'(CQZ), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
